// File: rtl/addr_cal_pkg.sv
// Shared types and helpers for the multi-buffer merge-pass write-address calculator.
package addr_cal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        READY,
        ISSUE,
        WAIT_DONE
    } wr_state_t;

    // Buffers rotate upward and wrap, so a phase starting at the last buffer visits 0 next.
    function automatic int unsigned next_buf_idx(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ch_base_table.sv
// Per-phase channel base table: fills one base address per cycle after a start pulse,
// then serves combinational reads by buffer index.
module ch_base_table #(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned NUM_BUF     = 2,
    parameter int unsigned CH_OFFSET   = 0,
    parameter int unsigned STRIDE_LOG2 = 30,
    parameter int unsigned IDX_W       = $clog2(NUM_BUF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_ptr,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_rd_base
);

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_base [NUM_BUF];
    logic [IDX_W-1:0]  r_cnt;
    logic              r_active;
    logic [ADDR_W-1:0] w_ch;

    assign w_ch      = ADDR_W'(CH_OFFSET) + ADDR_W'(r_cnt);
    assign o_done    = r_active && (r_cnt == IDX_W'(NUM_BUF - 1));
    assign o_rd_base = r_base[i_rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
        end else if (r_active) begin
            r_cnt <= r_cnt + 1'b1;
            if (o_done)
                r_active <= 1'b0;
        end
    end

    // Address storage carries no reset; it is only read after a full fill.
    always_ff @(posedge clk) begin
        if (!rst && i_start)
            r_ptr <= i_ptr;
        else if (r_active)
            r_base[r_cnt] <= r_ptr + (w_ch << STRIDE_LOG2);
    end

endmodule

// File: rtl/addr_cal_wr_multibuf.sv
// Write-address calculator for merge passes: rotates passes over channel buffers and
// tracks a byte offset so one pass can be written as several segments.
module addr_cal_wr_multibuf
    import addr_cal_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 64,
    parameter int unsigned C_CHANNEL_OFFSET   = 0,
    parameter int unsigned C_NUM_BUF          = 2,
    parameter int unsigned C_CH_STRIDE_LOG2   = 30
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            i_phase_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_ptr_ch_0,
    input  logic                            i_write_start,
    input  logic [C_XFER_SIZE_WIDTH-1:0]    i_write_size,
    input  logic                            i_pass_last,
    input  logic                            i_write_done,
    output logic                            o_write_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   o_write_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0]    o_write_size,
    output logic [$clog2(C_NUM_BUF)-1:0]    o_buf_idx,
    output logic                            o_busy,
    output logic                            o_err
);

    localparam int unsigned IDX_W = $clog2(C_NUM_BUF);
    localparam int unsigned OFF_W = C_CH_STRIDE_LOG2 + 1;
    localparam int unsigned SUM_W = ((C_XFER_SIZE_WIDTH > OFF_W) ? C_XFER_SIZE_WIDTH : OFF_W) + 1;

    wr_state_t                     r_state;
    logic [IDX_W-1:0]              r_idx;
    logic [IDX_W-1:0]              r_buf_idx;
    logic [OFF_W-1:0]              r_offset;
    logic                          r_pend;
    logic                          r_pend_last;
    logic [C_XFER_SIZE_WIDTH-1:0]  r_pend_size;
    logic                          r_last;
    logic                          r_start;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [C_XFER_SIZE_WIDTH-1:0]  r_size;
    logic                          r_busy;
    logic                          r_err;

    logic                          w_init_done;
    logic [C_M_AXI_ADDR_WIDTH-1:0] w_base;
    logic [SUM_W-1:0]              w_sum;
    logic                          w_ovf;

    ch_base_table #(
        .ADDR_W      (C_M_AXI_ADDR_WIDTH),
        .NUM_BUF     (C_NUM_BUF),
        .CH_OFFSET   (C_CHANNEL_OFFSET),
        .STRIDE_LOG2 (C_CH_STRIDE_LOG2),
        .IDX_W       (IDX_W)
    ) u_base_table (
        .clk       (aclk),
        .rst       (areset),
        .i_start   (i_phase_start),
        .i_ptr     (i_ptr_ch_0),
        .i_rd_idx  (r_idx),
        .o_done    (w_init_done),
        .o_rd_base (w_base)
    );

    // Sum is one bit wider than either operand so the overflow test never wraps.
    assign w_sum = SUM_W'(r_offset) + SUM_W'(r_size);
    assign w_ovf = w_sum > (SUM_W'(1) << C_CH_STRIDE_LOG2);

    always_ff @(posedge aclk) begin
        r_start <= 1'b0;
        if (areset) begin
            r_state   <= IDLE;
            r_idx     <= IDX_W'(C_NUM_BUF - 1);
            r_buf_idx <= '0;
            r_offset  <= '0;
            r_pend    <= 1'b0;
            r_last    <= 1'b0;
            r_addr    <= '0;
            r_size    <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_busy    <= (r_state == INIT) || (r_state == ISSUE) || (r_state == WAIT_DONE);
            r_buf_idx <= r_idx;
            if (i_phase_start) begin
                r_state     <= INIT;
                r_idx       <= IDX_W'(C_NUM_BUF - 1);
                r_offset    <= '0;
                r_err       <= 1'b0;
                r_pend      <= i_write_start;
                r_pend_size <= i_write_size;
                r_pend_last <= i_pass_last;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_write_start)
                            r_err <= 1'b1;
                    end
                    INIT: begin
                        if (i_write_start) begin
                            if (r_pend) begin
                                r_err <= 1'b1;
                            end else begin
                                r_pend      <= 1'b1;
                                r_pend_size <= i_write_size;
                                r_pend_last <= i_pass_last;
                            end
                        end
                        if (w_init_done)
                            r_state <= READY;
                    end
                    READY: begin
                        if (r_pend || i_write_start) begin
                            r_start <= 1'b1;
                            r_addr  <= w_base + C_M_AXI_ADDR_WIDTH'(r_offset);
                            r_size  <= r_pend ? r_pend_size : i_write_size;
                            r_last  <= r_pend ? r_pend_last : i_pass_last;
                            r_pend  <= 1'b0;
                            r_state <= ISSUE;
                            if (r_pend && i_write_start)
                                r_err <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        if (i_write_start)
                            r_err <= 1'b1;
                        r_state <= WAIT_DONE;
                    end
                    WAIT_DONE: begin
                        if (i_write_start)
                            r_err <= 1'b1;
                        if (i_write_done) begin
                            r_state <= READY;
                            if (w_ovf)
                                r_err <= 1'b1;
                            if (r_last) begin
                                r_offset <= '0;
                                r_idx    <= IDX_W'(next_buf_idx(32'(r_idx), C_NUM_BUF));
                            end else begin
                                r_offset <= w_sum[OFF_W-1:0];
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_write_start = r_start;
    assign o_write_addr  = r_addr;
    assign o_write_size  = r_size;
    assign o_buf_idx     = r_buf_idx;
    assign o_busy        = r_busy;
    assign o_err         = r_err;

endmodule

// File: tb/tb_addr_cal_wr_multibuf.sv
// Directed bench: three configurations share one stimulus stream, each scenario checks one.
module tb_addr_cal_wr_multibuf;

    logic        clk = 1'b0;
    logic        areset, i_phase_start, i_write_start, i_pass_last, i_write_done;
    logic [63:0] i_ptr, i_write_size;

    logic        o2_start, o4_start, o8_start;
    logic [63:0] o2_addr, o4_addr, o8_addr, o2_size, o4_size, o8_size;
    logic        o2_buf, o8_buf;
    logic [1:0]  o4_buf;
    logic        o2_busy, o4_busy, o8_busy, o2_err, o4_err, o8_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    addr_cal_wr_multibuf #(.C_CHANNEL_OFFSET(2), .C_NUM_BUF(2), .C_CH_STRIDE_LOG2(30)) dut2 (
        .aclk(clk), .areset(areset), .i_phase_start(i_phase_start), .i_ptr_ch_0(i_ptr),
        .i_write_start(i_write_start), .i_write_size(i_write_size), .i_pass_last(i_pass_last),
        .i_write_done(i_write_done), .o_write_start(o2_start), .o_write_addr(o2_addr),
        .o_write_size(o2_size), .o_buf_idx(o2_buf), .o_busy(o2_busy), .o_err(o2_err));

    addr_cal_wr_multibuf #(.C_CHANNEL_OFFSET(0), .C_NUM_BUF(4), .C_CH_STRIDE_LOG2(30)) dut4 (
        .aclk(clk), .areset(areset), .i_phase_start(i_phase_start), .i_ptr_ch_0(i_ptr),
        .i_write_start(i_write_start), .i_write_size(i_write_size), .i_pass_last(i_pass_last),
        .i_write_done(i_write_done), .o_write_start(o4_start), .o_write_addr(o4_addr),
        .o_write_size(o4_size), .o_buf_idx(o4_buf), .o_busy(o4_busy), .o_err(o4_err));

    addr_cal_wr_multibuf #(.C_CHANNEL_OFFSET(0), .C_NUM_BUF(2), .C_CH_STRIDE_LOG2(8)) dut8 (
        .aclk(clk), .areset(areset), .i_phase_start(i_phase_start), .i_ptr_ch_0(i_ptr),
        .i_write_start(i_write_start), .i_write_size(i_write_size), .i_pass_last(i_pass_last),
        .i_write_done(i_write_done), .o_write_start(o8_start), .o_write_addr(o8_addr),
        .o_write_size(o8_size), .o_buf_idx(o8_buf), .o_busy(o8_busy), .o_err(o8_err));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic phase(input logic [63:0] p, input int n);
        i_ptr = p;
        i_phase_start = 1'b1;
        tick();
        i_phase_start = 1'b0;
        repeat (n) tick();
    endtask

    task automatic seg_start(input logic [63:0] sz, input logic last);
        i_write_size  = sz;
        i_pass_last   = last;
        i_write_start = 1'b1;
        tick();
        i_write_start = 1'b0;
    endtask

    task automatic seg_finish();
        tick();
        i_write_done = 1'b1;
        tick();
        i_write_done = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick();
        tick();
        n_cmp++; if (o2_start !== 1'b0) begin n_err++; $display("FAIL rst_start got %0b want 0", o2_start); end
        n_cmp++; if (o2_addr !== 64'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", o2_addr); end
        n_cmp++; if (o2_size !== 64'h0) begin n_err++; $display("FAIL rst_size got %h want 0", o2_size); end
        n_cmp++; if (o2_buf !== 1'b0) begin n_err++; $display("FAIL rst_buf got %0d want 0", o2_buf); end
        n_cmp++; if (o2_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0b want 0", o2_busy); end
        n_cmp++; if (o2_err !== 1'b0) begin n_err++; $display("FAIL rst_err got %0b want 0", o2_err); end
        areset = 1'b0;
        tick();
        seg_start(64'h10, 1'b1);
        n_cmp++; if (o2_err !== 1'b1) begin n_err++; $display("FAIL idle_start_err got %0b want 1", o2_err); end
        n_cmp++; if (o2_start !== 1'b0) begin n_err++; $display("FAIL idle_no_issue got %0b want 0", o2_start); end
    endtask

    task automatic test_init();
        int n_busy;
        i_ptr = 64'h1000_0000;
        i_phase_start = 1'b1;
        tick();
        i_phase_start = 1'b0;
        n_cmp++; if (o2_err !== 1'b0) begin n_err++; $display("FAIL phase_clr_err got %0b want 0", o2_err); end
        n_busy = int'(o2_busy);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_busy += int'(o2_busy);
        end
        n_cmp++; if (n_busy != 2) begin n_err++; $display("FAIL init_busy_cycles got %0d want 2", n_busy); end
        seg_start(64'h100, 1'b1);
        n_cmp++; if (o2_start !== 1'b1) begin n_err++; $display("FAIL init_issue got %0b want 1", o2_start); end
        n_cmp++; if (o2_addr !== 64'hD000_0000) begin n_err++; $display("FAIL init_addr got %h want %h", o2_addr, 64'hD000_0000); end
        n_cmp++; if (o2_size !== 64'h100) begin n_err++; $display("FAIL init_size got %h want 100", o2_size); end
        n_cmp++; if (o2_buf !== 1'b1) begin n_err++; $display("FAIL init_buf got %0d want 1", o2_buf); end
        tick();
        n_cmp++; if (o2_start !== 1'b0) begin n_err++; $display("FAIL issue_one_cycle got %0b want 0", o2_start); end
        i_write_done = 1'b1;
        tick();
        i_write_done = 1'b0;
    endtask

    task automatic test_ping_pong();
        logic [63:0] exp_a [3] = '{64'hD000_0000, 64'h9000_0000, 64'hD000_0000};
        logic        exp_b [3] = '{1'b1, 1'b0, 1'b1};
        phase(64'h1000_0000, 2);
        for (int i = 0; i < 3; i++) begin
            seg_start(64'h20, 1'b1);
            n_cmp++; if (o2_addr !== exp_a[i]) begin n_err++; $display("FAIL pp_addr[%0d] got %h want %h", i, o2_addr, exp_a[i]); end
            n_cmp++; if (o2_buf !== exp_b[i]) begin n_err++; $display("FAIL pp_buf[%0d] got %0d want %0d", i, o2_buf, exp_b[i]); end
            seg_finish();
        end
    endtask

    task automatic test_multi_seg();
        logic [63:0] sz    [5] = '{64'h0, 64'h40, 64'h80, 64'hC0, 64'h10};
        logic        lst   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [63:0] exp_a [5] = '{64'hD000_0000, 64'hD000_0000, 64'hD000_0040, 64'hD000_00C0, 64'h9000_0000};
        phase(64'h1000_0000, 2);
        for (int i = 0; i < 5; i++) begin
            seg_start(sz[i], lst[i]);
            n_cmp++; if (o2_addr !== exp_a[i]) begin n_err++; $display("FAIL ms_addr[%0d] got %h want %h", i, o2_addr, exp_a[i]); end
            n_cmp++; if (o2_size !== sz[i]) begin n_err++; $display("FAIL ms_size[%0d] got %h want %h", i, o2_size, sz[i]); end
            seg_finish();
        end
    endtask

    task automatic test_four_buf();
        logic [63:0] exp_a [5] = '{64'hD000_0000, 64'h1000_0000, 64'h5000_0000, 64'h9000_0000, 64'hD000_0000};
        logic [1:0]  exp_b [5] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        phase(64'h1000_0000, 4);
        n_cmp++; if (o4_busy !== 1'b1) begin n_err++; $display("FAIL fb_busy got %0b want 1", o4_busy); end
        for (int i = 0; i < 5; i++) begin
            seg_start(64'h10, 1'b1);
            n_cmp++; if (o4_start !== 1'b1) begin n_err++; $display("FAIL fb_issue[%0d] got %0b want 1", i, o4_start); end
            n_cmp++; if (o4_addr !== exp_a[i]) begin n_err++; $display("FAIL fb_addr[%0d] got %h want %h", i, o4_addr, exp_a[i]); end
            n_cmp++; if (o4_buf !== exp_b[i]) begin n_err++; $display("FAIL fb_buf[%0d] got %0d want %0d", i, o4_buf, exp_b[i]); end
            n_cmp++; if (o4_size !== 64'h10) begin n_err++; $display("FAIL fb_size[%0d] got %h want 10", i, o4_size); end
            seg_finish();
        end
        n_cmp++; if (o4_err !== 1'b0) begin n_err++; $display("FAIL fb_err got %0b want 0", o4_err); end
    endtask

    task automatic test_protocol();
        phase(64'h1000_0000, 0);
        seg_start(64'h20, 1'b1);
        n_cmp++; if (o2_start !== 1'b0) begin n_err++; $display("FAIL pend_early1 got %0b want 0", o2_start); end
        tick();
        n_cmp++; if (o2_start !== 1'b0) begin n_err++; $display("FAIL pend_early2 got %0b want 0", o2_start); end
        tick();
        n_cmp++; if (o2_start !== 1'b1) begin n_err++; $display("FAIL pend_issue got %0b want 1", o2_start); end
        n_cmp++; if (o2_addr !== 64'hD000_0000) begin n_err++; $display("FAIL pend_addr got %h want %h", o2_addr, 64'hD000_0000); end
        n_cmp++; if (o2_size !== 64'h20) begin n_err++; $display("FAIL pend_size got %h want 20", o2_size); end
        n_cmp++; if (o2_err !== 1'b0) begin n_err++; $display("FAIL pend_err got %0b want 0", o2_err); end
        tick();
        seg_start(64'h30, 1'b0);
        n_cmp++; if (o2_err !== 1'b1) begin n_err++; $display("FAIL wait_start_err got %0b want 1", o2_err); end
        n_cmp++; if (o2_start !== 1'b0) begin n_err++; $display("FAIL wait_no_issue got %0b want 0", o2_start); end
        i_write_done = 1'b1;
        tick();
        i_write_done = 1'b0;
        phase(64'h1000_0000, 2);
        n_cmp++; if (o2_err !== 1'b0) begin n_err++; $display("FAIL phase_clears_err got %0b want 0", o2_err); end
        i_write_done = 1'b1;
        tick();
        i_write_done = 1'b0;
        n_cmp++; if (o2_err !== 1'b0) begin n_err++; $display("FAIL stray_done_err got %0b want 0", o2_err); end
    endtask

    task automatic test_overflow();
        phase(64'h1000, 2);
        n_cmp++; if (o8_busy !== 1'b1) begin n_err++; $display("FAIL ov_busy got %0b want 1", o8_busy); end
        seg_start(64'h80, 1'b0);
        n_cmp++; if (o8_start !== 1'b1) begin n_err++; $display("FAIL ov_issue got %0b want 1", o8_start); end
        n_cmp++; if (o8_addr !== 64'h1100) begin n_err++; $display("FAIL ov_addr0 got %h want 1100", o8_addr); end
        n_cmp++; if (o8_buf !== 1'b1) begin n_err++; $display("FAIL ov_buf got %0d want 1", o8_buf); end
        seg_finish();
        seg_start(64'h80, 1'b1);
        n_cmp++; if (o8_addr !== 64'h1180) begin n_err++; $display("FAIL ov_addr1 got %h want 1180", o8_addr); end
        seg_finish();
        n_cmp++; if (o8_err !== 1'b0) begin n_err++; $display("FAIL ov_exact_fit got %0b want 0", o8_err); end
        phase(64'h1000, 2);
        seg_start(64'h80, 1'b0);
        seg_finish();
        seg_start(64'h90, 1'b1);
        n_cmp++; if (o8_size !== 64'h90) begin n_err++; $display("FAIL ov_size got %h want 90", o8_size); end
        n_cmp++; if (o8_err !== 1'b0) begin n_err++; $display("FAIL ov_err_early got %0b want 0", o8_err); end
        seg_finish();
        n_cmp++; if (o8_err !== 1'b1) begin n_err++; $display("FAIL ov_err got %0b want 1", o8_err); end
    endtask

    task automatic test_override();
        phase(64'h1000_0000, 2);
        seg_start(64'h10, 1'b1);
        seg_finish();
        seg_start(64'h20, 1'b0);
        n_cmp++; if (o2_addr !== 64'h9000_0000) begin n_err++; $display("FAIL ovr_addr0 got %h want %h", o2_addr, 64'h9000_0000); end
        tick();
        i_phase_start = 1'b1;
        i_write_done  = 1'b1;
        tick();
        i_phase_start = 1'b0;
        i_write_done  = 1'b0;
        tick();
        tick();
        seg_start(64'h30, 1'b1);
        n_cmp++; if (o2_addr !== 64'hD000_0000) begin n_err++; $display("FAIL ovr_addr1 got %h want %h", o2_addr, 64'hD000_0000); end
        n_cmp++; if (o2_buf !== 1'b1) begin n_err++; $display("FAIL ovr_buf got %0d want 1", o2_buf); end
        tick();
        areset = 1'b1;
        i_phase_start = 1'b1;
        tick();
        areset = 1'b0;
        i_phase_start = 1'b0;
        n_cmp++; if (o2_addr !== 64'h0) begin n_err++; $display("FAIL ar_addr got %h want 0", o2_addr); end
        n_cmp++; if (o2_size !== 64'h0) begin n_err++; $display("FAIL ar_size got %h want 0", o2_size); end
        n_cmp++; if (o2_busy !== 1'b0) begin n_err++; $display("FAIL ar_busy got %0b want 0", o2_busy); end
        n_cmp++; if (o2_buf !== 1'b0) begin n_err++; $display("FAIL ar_buf got %0d want 0", o2_buf); end
        tick();
        tick();
        n_cmp++; if (o2_busy !== 1'b0) begin n_err++; $display("FAIL ar_idle got %0b want 0", o2_busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        i_phase_start = 1'b0;
        i_write_start = 1'b0;
        i_pass_last = 1'b0;
        i_write_done = 1'b0;
        i_ptr = 64'h0;
        i_write_size = 64'h0;
        test_reset();
        test_init();
        test_ping_pong();
        test_multi_seg();
        test_four_buf();
        test_protocol();
        test_overflow();
        test_override();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
